fifo_rd_fwft: RTL and testbench
===============================

Name: fifo_rd_fwft

Overview:
- Read-side output stage of the async FIFO, directly downstream of the read pointer/empty logic and the dual-port memory.
- Converts the native read interface (r_inc / empty / registered rd_data) into a first-word-fall-through valid/ready stream.
- Prefetches up to 3 words into a local buffer so the consumer sees full throughput with no combinational path from m_ready to r_inc.

Parameters:
- D_SIZE, 8, data word width.
- BUF_DEPTH, 3, prefetch buffer entries. Fixed at 3 for full throughput with registered credit; other values are not supported.

Ports:
- r_clk  input  1  read-domain clock
- r_rstn  input  1  asynchronous active-low reset
- empty  input  1  FIFO empty flag from the read pointer block
- rd_data  input  D_SIZE  memory read data; valid exactly one cycle after a r_inc pulse
- r_inc  output  1  read request to the pointer block; one word popped per high cycle
- m_data  output  D_SIZE  head-of-buffer data
- m_valid  output  1  m_data holds a valid word
- m_ready  input  1  consumer accepts m_data this cycle
- buf_cnt  output  2  words currently held in the buffer (0..3)

Behaviour:
- State registers:
  - occ: 0..3, buffered words.
  - infl: 0/1, read issued last cycle.
  - head, tail: 0..2 circular indices.
  - buf[0..2]: storage.
- r_inc = !empty && (occ + infl < 3). It depends only on registered state and empty; never on m_ready.
- Issue at cycle N: infl=1 in N+1. In N+1, rd_data is written to buf[tail], tail advances mod 3, occ increments.
- m_valid = (occ != 0); m_data = buf[head]; buf_cnt = occ.
- pop = m_valid && m_ready: head advances mod 3, occ decrements.
- Land and pop in the same cycle: occ unchanged, both indices advance.
- Latency: r_inc at N, m_valid first high at N+2 when the buffer was empty.
- Throughput: sustained 1 word/cycle with empty=0 and m_ready=1.
- Stability: while m_valid && !m_ready, m_data and m_valid hold unchanged.
- Ordering: words leave in exactly the order issued; no loss, no duplication.
- Overflow: occ + infl never exceeds 3. A land with occ=3 is illegal and must be caught by an assertion.
- Wrap: head and tail wrap 2 -> 0.
- empty asserting while infl=1: the in-flight word still lands and is buffered.
- Reset, asynchronous with r_rstn low:
  - occ, infl, head, tail, and all buf entries clear to 0.
  - Hence r_inc=0, m_valid=0, m_data=0, buf_cnt=0, immediately (not clock-dependent).
  - In-flight and buffered words are discarded; the pointer block resets with the same r_rstn.
- Reset release: the first r_inc occurs on the first edge where empty=0.

Decomposition:
- Shared package: BUF_DEPTH constant, count width (2), index width (2), and a mod-3 increment function.
- Sub-module fifo_fwft_buf: 3-entry register file with head/tail/occ bookkeeping, write-enable and pop inputs.
- fifo_rd_fwft keeps the credit logic (infl, r_inc) and the output mapping.

Test Plan:
- Reset: r_rstn=0 at arbitrary time, with buffer holding 2 words and infl=1 -> r_inc, m_valid, buf_cnt, m_data all 0 without a clock edge. After release with empty=1, no word ever appears.
- Single word: empty=0 only at cycle N, rd_data=0xA5 at N+1, m_ready=1 -> r_inc high at N only; m_valid=1 with m_data=0xA5 at N+2 only; buf_cnt returns to 0 at N+3.
- Streaming: empty=0, m_ready=1, rd_data 0x01,0x02,0x03... -> r_inc high every cycle; m_data 0x01,0x02,... on consecutive cycles from N+2 with no bubbles.
- Backpressure: empty=0, m_ready=0 -> exactly 3 r_inc pulses; buf_cnt=3; r_inc then stays 0; m_data stable at the first word. Raise m_ready -> all words in order, then r_inc resumes.
- Empty mid-flight: empty rises the cycle after an issue -> the landed word is still buffered and delivered; no further r_inc.
- Random: empty and m_ready each toggled at 50% for 10k cycles -> scoreboard matches issue order; occ + infl <= 3 assertion never fires; data is stable under stall.

Source files
------------

// File: rtl/fifo_rd_fwft_pkg.sv
// fifo_rd_fwft shared constants and helpers
// prefetch buffer sizing and mod-3 index arithmetic
package fifo_rd_fwft_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 2;
  localparam int IDX_W     = 2;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t inc3(input idx_t i);
    return (i == idx_t'(BUF_DEPTH - 1)) ? '0 : i + idx_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// fifo_rd_fwft bus: native read side plus stream side
// master = the FWFT stage, slave = pointer block / consumer
interface fifo_rd_fwft_if #(
  parameter int D_SIZE = 8
);
  import fifo_rd_fwft_pkg::*;

  logic              empty;
  logic [D_SIZE-1:0] rd_data;
  logic              r_inc;
  logic [D_SIZE-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  cnt_t              buf_cnt;

  modport master (
    input  empty,
    input  rd_data,
    input  m_ready,
    output r_inc,
    output m_data,
    output m_valid,
    output buf_cnt
  );

  modport slave (
    output empty,
    output rd_data,
    output m_ready,
    input  r_inc,
    input  m_data,
    input  m_valid,
    input  buf_cnt
  );

endinterface

// File: rtl/fifo_fwft_buf.sv
// fifo_fwft_buf: 3-entry circular prefetch buffer
// write lands at tail, head is always presented
module fifo_fwft_buf
  import fifo_rd_fwft_pkg::*;
#(
  parameter int D_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [D_SIZE-1:0] wdata_i,
  input  logic              pop_i,
  output logic [D_SIZE-1:0] rdata_o,
  output cnt_t              occ_o
);

  logic [D_SIZE-1:0] mem_q [BUF_DEPTH];
  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t occ_q, occ_d;

  // index and occupancy next-state
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (pop_i) head_d = inc3(head_q);
    if (we_i)  tail_d = inc3(tail_q);
    unique case (1'b1)
      (we_i && !pop_i): occ_d = occ_q + cnt_t'(1);
      (!we_i && pop_i): occ_d = occ_q - cnt_t'(1);
      default:          occ_d = occ_q;
    endcase
  end

  // bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // storage; cleared so m_data reads 0 in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign occ_o   = occ_q;

  a_no_land_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(we_i && occ_q == cnt_t'(BUF_DEPTH)));

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop_i && occ_q == '0));

endmodule

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: async FIFO read side to FWFT stream
// credit = occ + in-flight; r_inc never sees m_ready
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int D_SIZE    = 8,
  parameter int BUF_DEPTH = fifo_rd_fwft_pkg::BUF_DEPTH
) (
  input  logic            r_clk,
  input  logic            r_rstn,
  fifo_rd_fwft_if.master  bus
);

  logic              infl_q, infl_d;
  logic              r_inc;
  logic              pop;
  logic [2:0]        credit;
  cnt_t              occ;
  logic [D_SIZE-1:0] head_data;

  assign credit = {1'b0, occ} + {2'b00, infl_q};
  assign r_inc  = r_rstn && !bus.empty
               && (credit < 3'(BUF_DEPTH));
  assign pop    = (occ != '0) && bus.m_ready;

  // a request issued now lands next cycle
  always_comb begin
    infl_d = r_inc;
  end

  // in-flight flag register
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) infl_q <= 1'b0;
    else         infl_q <= infl_d;
  end

  fifo_fwft_buf #(
    .D_SIZE (D_SIZE)
  ) u_buf (
    .clk     (r_clk),
    .rst_n   (r_rstn),
    .we_i    (infl_q),
    .wdata_i (bus.rd_data),
    .pop_i   (pop),
    .rdata_o (head_data),
    .occ_o   (occ)
  );

  assign bus.r_inc   = r_inc;
  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = head_data;
  assign bus.buf_cnt = occ;

  a_credit: assert property (
    @(posedge r_clk) disable iff (!r_rstn)
    credit <= 3'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: directed + random check of the FWFT stage
// memory model returns base+n one cycle after each r_inc
module tb_fifo_rd_fwft;

  logic r_clk  = 1'b0;
  logic r_rstn = 1'b1;
  always #5 r_clk = ~r_clk;

  fifo_rd_fwft_if #(.D_SIZE(8)) vif ();

  fifo_rd_fwft #(.D_SIZE(8)) dut (
    .r_clk  (r_clk),
    .r_rstn (r_rstn),
    .bus    (vif)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] base  = 8'd0;
  logic [7:0] n_iss = 8'd0;
  logic [7:0] sb [$];

  // pointer block + memory model
  always @(posedge r_clk) begin
    if (vif.r_inc) begin
      vif.rd_data <= base + n_iss;
      sb.push_back(base + n_iss);
      n_iss <= n_iss + 8'd1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge r_clk);
  endtask

  int         cnt;
  logic       stall;
  logic [7:0] prev;
  logic [7:0] w;

  initial begin
    vif.empty   = 1'b1;
    vif.m_ready = 1'b0;

    // power-on reset, no clock edge yet
    #1 r_rstn = 1'b0;
    #2;
    chk("por_rinc",  32'(vif.r_inc),   0);
    chk("por_valid", 32'(vif.m_valid), 0);
    chk("por_cnt",   32'(vif.buf_cnt), 0);
    chk("por_data",  32'(vif.m_data),  0);
    cyc(); cyc();
    r_rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("idle_rinc",  32'(vif.r_inc),   0);
      chk("idle_valid", 32'(vif.m_valid), 0);
    end

    // single word 0xA5
    cyc();
    base = 8'hA5 - n_iss;
    vif.empty = 1'b0; vif.m_ready = 1'b1;
    #1 chk("sw_rinc_n", 32'(vif.r_inc), 1);
    chk("sw_valid_n", 32'(vif.m_valid), 0);
    cyc(); vif.empty = 1'b1;
    #1 chk("sw_rinc_n1", 32'(vif.r_inc), 0);
    chk("sw_valid_n1", 32'(vif.m_valid), 0);
    cyc(); #1;
    chk("sw_valid_n2", 32'(vif.m_valid), 1);
    chk("sw_data_n2",  32'(vif.m_data),  32'h A5);
    chk("sw_cnt_n2",   32'(vif.buf_cnt), 1);
    cyc(); #1;
    chk("sw_valid_n3", 32'(vif.m_valid), 0);
    chk("sw_cnt_n3",   32'(vif.buf_cnt), 0);

    // streaming 1..8, no bubbles
    cyc();
    base = 8'd1 - n_iss;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) cyc();
      vif.empty = (i < 8) ? 1'b0 : 1'b1;
      #1;
      chk("st_rinc", 32'(vif.r_inc), (i < 8) ? 1 : 0);
      chk("st_valid", 32'(vif.m_valid),
          (i >= 2 && i < 10) ? 1 : 0);
      if (i >= 2 && i < 10)
        chk("st_data", 32'(vif.m_data), i - 1);
    end

    // backpressure: three credits then stop
    cyc();
    base = 8'h10 - n_iss;
    vif.empty = 1'b0; vif.m_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      #1;
      if (vif.r_inc) cnt++;
      if (i >= 2) chk("bp_hold_data", 32'(vif.m_data), 32'h10);
    end
    chk("bp_pulses", cnt, 3);
    chk("bp_cnt",    32'(vif.buf_cnt), 3);
    chk("bp_valid",  32'(vif.m_valid), 1);
    for (int j = 0; j < 9; j++) begin
      cyc();
      vif.m_ready = 1'b1;
      vif.empty   = (j < 6) ? 1'b0 : 1'b1;
      #1;
      chk("bp_rinc", 32'(vif.r_inc), (j >= 1 && j < 6) ? 1 : 0);
      chk("bp_valid_d", 32'(vif.m_valid), (j < 8) ? 1 : 0);
      if (j < 8) chk("bp_order", 32'(vif.m_data), 32'h10 + j);
    end

    // empty rises right after an issue
    cyc();
    base = 8'h5A - n_iss;
    vif.empty = 1'b0; vif.m_ready = 1'b0;
    #1 chk("mf_rinc0", 32'(vif.r_inc), 1);
    cyc(); vif.empty = 1'b1;
    #1 chk("mf_rinc1", 32'(vif.r_inc), 0);
    cyc(); #1;
    chk("mf_cnt",  32'(vif.buf_cnt), 1);
    chk("mf_data", 32'(vif.m_data),  32'h5A);
    cyc(); #1;
    chk("mf_rinc3", 32'(vif.r_inc),  0);
    chk("mf_hold",  32'(vif.m_data), 32'h5A);
    cyc(); vif.m_ready = 1'b1;
    cyc(); #1;
    chk("mf_drain", 32'(vif.buf_cnt), 0);

    // async reset with 2 buffered and 1 in flight
    cyc();
    base = 8'h80 - n_iss;
    vif.empty = 1'b0; vif.m_ready = 1'b0;
    cyc(); cyc(); cyc(); #1;
    chk("ar_pre_cnt", 32'(vif.buf_cnt), 2);
    #2 r_rstn = 1'b0;
    #1;
    chk("ar_rinc",  32'(vif.r_inc),   0);
    chk("ar_valid", 32'(vif.m_valid), 0);
    chk("ar_cnt",   32'(vif.buf_cnt), 0);
    chk("ar_data",  32'(vif.m_data),  0);
    cyc(); vif.empty = 1'b1;
    cyc(); r_rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("ar_no_word", 32'(vif.m_valid), 0);
      chk("ar_no_rinc", 32'(vif.r_inc),   0);
    end
    sb.delete();
    cyc();
    vif.empty = 1'b0;
    #1 chk("rel_first_rinc", 32'(vif.r_inc), 1);

    // random empty / m_ready, scoreboard order + stall stability
    stall = 1'b0;
    prev  = 8'd0;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (stall) begin
        chk("rnd_stall_valid", 32'(vif.m_valid), 1);
        chk("rnd_stall_data",  32'(vif.m_data),  32'(prev));
      end
      vif.empty   = 1'($urandom_range(0, 1));
      vif.m_ready = 1'($urandom_range(0, 1));
      #1;
      stall = vif.m_valid && !vif.m_ready;
      prev  = vif.m_data;
      if (vif.m_valid && vif.m_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_sb_under", 32'(sb.size()), 1);
        end else begin
          w = sb.pop_front();
          chk("rnd_order", 32'(vif.m_data), 32'(w));
        end
      end
    end

    // drain
    cyc();
    vif.empty = 1'b1; vif.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (vif.m_valid) begin
        if (sb.size() == 0) begin
          chk("dr_sb_under", 32'(sb.size()), 1);
        end else begin
          w = sb.pop_front();
          chk("dr_order", 32'(vif.m_data), 32'(w));
        end
      end
      cyc();
    end
    #1;
    chk("dr_sb_left", 32'(sb.size()),  0);
    chk("dr_valid",   32'(vif.m_valid), 0);
    chk("dr_cnt",     32'(vif.buf_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
